// File: rtl/pipe_stage_skid_pkg.sv
// Shared control encodings and reset-value defaults for the pipeline stage register.
package pipe_stage_skid_pkg;

  typedef enum logic [1:0] {
    CTRL_DEFAULT = 2'b00,
    CTRL_STALLED = 2'b01,
    CTRL_BUBBLE  = 2'b10,
    CTRL_RSVD    = 2'b11
  } ctrl_e;

  localparam logic [31:0] NOP_INSN   = 32'h0000_0013;
  localparam logic [63:0] INVALID_PC = 64'h0;

  // The reserved encoding behaves exactly like Bubble, so only the MSB matters.
  function automatic logic ctrl_is_bubble(input logic [1:0] ctrl);
    return ctrl[1];
  endfunction

  function automatic logic ctrl_is_stalled(input logic [1:0] ctrl);
    return ctrl == CTRL_STALLED;
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One storage slot: valid bit plus PC/payload. Clearing reloads the NOP/invalid-PC
// values so an empty slot never holds stale data on its outputs.
module pipe_entry_reg
  import pipe_stage_skid_pkg::*;
#(
  parameter int                PC_W    = 64,
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] NOP_VAL = DATA_W'(NOP_INSN),
  parameter logic [PC_W-1:0]   INV_PC  = PC_W'(INVALID_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              ld_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [PC_W-1:0]   pc_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_d, valid_q;
  logic [PC_W-1:0]   pc_d, pc_q;
  logic [DATA_W-1:0] data_d, data_q;

  // Clear wins over load; otherwise hold.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    data_d  = data_q;
    if (clr_i) begin
      valid_d = 1'b0;
      pc_d    = INV_PC;
      data_d  = NOP_VAL;
    end else if (ld_i) begin
      valid_d = 1'b1;
      pc_d    = pc_i;
      data_d  = data_i;
    end
  end

  // Slot register with synchronous reset to the empty values.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= INV_PC;
      data_q  <= NOP_VAL;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid (head H, skid S),
// Default/Stalled/Bubble control and a saturating stall-cycle counter.
// in_ready_o is registered, so downstream ready never reaches upstream combinationally.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int                PC_W    = 64,
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] NOP_VAL = DATA_W'(NOP_INSN),
  parameter logic [PC_W-1:0]   INV_PC  = PC_W'(INVALID_PC),
  parameter int                CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        ctrl_signal_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [PC_W-1:0]   pc_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        count_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  logic              h_valid, s_valid;
  logic [PC_W-1:0]   h_pc, s_pc, h_pc_in;
  logic [DATA_W-1:0] h_data, s_data, h_data_in;
  logic              h_ld, h_clr, h_from_s, s_ld, s_clr;
  logic              bubble, stalled, push, pop;
  logic              h_v_nxt, s_v_nxt;
  logic [1:0]        count_d, count_q;
  logic              in_ready_d, in_ready_q;
  logic [CNT_W-1:0]  stall_cnt_d, stall_cnt_q;

  assign bubble  = ctrl_is_bubble(ctrl_signal_i);
  assign stalled = ctrl_is_stalled(ctrl_signal_i);
  assign push    = in_valid_i & in_ready_q;
  assign pop     = h_valid & out_ready_i;

  // Slot steering: S always refills H first so H is the oldest entry.
  always_comb begin
    h_ld     = 1'b0;
    h_clr    = 1'b0;
    h_from_s = 1'b0;
    s_ld     = 1'b0;
    s_clr    = 1'b0;
    if (bubble) begin
      h_clr = 1'b1;
      s_clr = 1'b1;
    end else if (!stalled) begin
      unique case ({push, pop})
        2'b10: begin
          if (!h_valid)      h_ld = 1'b1;
          else if (!s_valid) s_ld = 1'b1;
        end
        2'b01: begin
          if (s_valid) begin
            h_ld     = 1'b1;
            h_from_s = 1'b1;
            s_clr    = 1'b1;
          end else begin
            h_clr = 1'b1;
          end
        end
        2'b11: begin
          h_ld = 1'b1;
          if (s_valid) begin
            h_from_s = 1'b1;
            s_ld     = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign h_pc_in   = h_from_s ? s_pc : pc_i;
  assign h_data_in = h_from_s ? s_data : data_i;

  // Occupancy, ready and stall counter for the next cycle.
  always_comb begin
    h_v_nxt = h_clr ? 1'b0 : (h_ld ? 1'b1 : h_valid);
    s_v_nxt = s_clr ? 1'b0 : (s_ld ? 1'b1 : s_valid);
    count_d = {1'b0, h_v_nxt} + {1'b0, s_v_nxt};
    in_ready_d = !stalled && (count_d != 2'd2);
    stall_cnt_d = stall_cnt_q;
    if (stalled && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // Control registers; reset leaves the stage empty and ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= 2'd0;
      in_ready_q  <= 1'b1;
      stall_cnt_q <= '0;
    end else begin
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  pipe_entry_reg #(
    .PC_W(PC_W), .DATA_W(DATA_W), .NOP_VAL(NOP_VAL), .INV_PC(INV_PC)
  ) u_head (
    .clk(clk), .rst(rst), .clr_i(h_clr), .ld_i(h_ld),
    .pc_i(h_pc_in), .data_i(h_data_in),
    .valid_o(h_valid), .pc_o(h_pc), .data_o(h_data)
  );

  pipe_entry_reg #(
    .PC_W(PC_W), .DATA_W(DATA_W), .NOP_VAL(NOP_VAL), .INV_PC(INV_PC)
  ) u_skid (
    .clk(clk), .rst(rst), .clr_i(s_clr), .ld_i(s_ld),
    .pc_i(pc_i), .data_i(data_i),
    .valid_o(s_valid), .pc_o(s_pc), .data_o(s_data)
  );

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = h_valid;
  assign pc_o        = h_pc;
  assign data_o      = h_data;
  assign count_o     = count_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios then random traffic, all checked
// against a queue-based model of the stage. A second instance with CNT_W=2
// exercises stall counter saturation on the same stimulus.
module tb_pipe_stage_skid;

  localparam logic [63:0] INV = 64'h0;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  ctrl = 2'b00;
  logic        in_valid = 1'b0;
  logic [63:0] pc_in = '0;
  logic [31:0] data_in = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, in_ready_2, out_valid_2;
  logic [63:0] pc_out, pc_out_2;
  logic [31:0] data_out, data_out_2;
  logic [1:0]  count, count_2;
  logic [15:0] stall_cnt;
  logic [1:0]  stall_cnt_2;

  always #5 clk = ~clk;

  pipe_stage_skid dut (
    .clk(clk), .rst(rst), .ctrl_signal_i(ctrl),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .pc_i(pc_in), .data_i(data_in),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .pc_o(pc_out), .data_o(data_out),
    .count_o(count), .stall_cnt_o(stall_cnt)
  );

  pipe_stage_skid #(.CNT_W(2)) dut_c2 (
    .clk(clk), .rst(rst), .ctrl_signal_i(ctrl),
    .in_valid_i(in_valid), .in_ready_o(in_ready_2),
    .pc_i(pc_in), .data_i(data_in),
    .out_valid_o(out_valid_2), .out_ready_i(out_ready),
    .pc_o(pc_out_2), .data_o(data_out_2),
    .count_o(count_2), .stall_cnt_o(stall_cnt_2)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  bit          m_ready = 1'b1;
  int          m_stall = 0;
  bit          hold_pend = 1'b0;
  logic [63:0] hold_pc;
  logic [31:0] hold_data;
  bit          up_acc;
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc_n = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc_n, got, exp);
    end
  endtask

  task automatic cyc(input bit r, input logic [1:0] c, input bit v,
                     input logic [63:0] p, input logic [31:0] d, input bit ordy);
    bit ready_before;
    bit do_pop;
    bit do_push;
    logic [63:0] exp_pc;
    logic [31:0] exp_data;
    if (hold_pend && !r)
      assert (v && p == hold_pc && d == hold_data)
        else $error("FAIL proto cycle %0d: upstream changed while held", cyc_n);
    rst = r; ctrl = c; in_valid = v; pc_in = p; data_in = d; out_ready = ordy;
    @(posedge clk);
    cyc_n++;
    ready_before = m_ready;
    up_acc = 1'b0;
    if (r) begin
      mq.delete();
      m_ready = 1'b1;
      m_stall = 0;
    end else if (c[1]) begin
      up_acc = v && m_ready;
      mq.delete();
      m_ready = 1'b1;
    end else if (c == 2'b01) begin
      up_acc = v && m_ready;
      m_stall++;
      m_ready = 1'b0;
    end else begin
      do_pop  = (mq.size() > 0) && ordy;
      do_push = v && m_ready;
      up_acc  = do_push;
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back('{pc: p, data: d});
      m_ready = mq.size() < 2;
    end
    hold_pend = !r && v && !ready_before;
    hold_pc   = p;
    hold_data = d;
    #1;
    exp_pc   = INV;
    exp_data = NOP;
    if (mq.size() > 0) begin
      exp_pc   = mq[0].pc;
      exp_data = mq[0].data;
    end
    chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
    chk("pc_o", pc_out, exp_pc);
    chk("data_o", 64'(data_out), 64'(exp_data));
    chk("count_o", 64'(count), 64'(mq.size()));
    chk("in_ready", 64'(in_ready), 64'(m_ready));
    chk("stall_cnt", 64'(stall_cnt), 64'((m_stall > 65535) ? 65535 : m_stall));
    chk("stall_cnt_w2", 64'(stall_cnt_2), 64'((m_stall > 3) ? 3 : m_stall));
    chk("count_w2", 64'(count_2), 64'(mq.size()));
  endtask

  initial begin : main
    logic [63:0] up_pc;
    logic [31:0] up_d;
    bit          up_v;
    bit          need_new;
    int          seq;
    int          rr;
    bit          r;
    logic [1:0]  c;

    // reset with valid input asserted
    cyc(1, 2'b00, 1, 64'h1234, 32'hdead_beef, 0);
    cyc(1, 2'b00, 1, 64'h1234, 32'hdead_beef, 0);

    // single push then pop
    cyc(0, 2'b00, 1, 64'h8000_0000, 32'h0010_0093, 1);
    cyc(0, 2'b00, 0, 64'h0, 32'h0, 1);
    cyc(0, 2'b00, 0, 64'h0, 32'h0, 1);

    // fill under backpressure, third held, then drain in order
    cyc(0, 2'b00, 1, 64'h8000_0010, 32'haaaa_0001, 0);
    cyc(0, 2'b00, 1, 64'h8000_0014, 32'haaaa_0002, 0);
    cyc(0, 2'b00, 1, 64'h8000_0018, 32'haaaa_0003, 0);
    cyc(0, 2'b00, 1, 64'h8000_0018, 32'haaaa_0003, 0);
    cyc(0, 2'b00, 1, 64'h8000_0018, 32'haaaa_0003, 1);
    cyc(0, 2'b00, 1, 64'h8000_0018, 32'haaaa_0003, 1);
    cyc(0, 2'b00, 0, 64'h0, 32'h0, 1);
    cyc(0, 2'b00, 0, 64'h0, 32'h0, 1);

    // full, stalled 5 cycles with downstream ready, then drain
    cyc(0, 2'b00, 1, 64'h8000_0020, 32'hbbbb_0001, 0);
    cyc(0, 2'b00, 1, 64'h8000_0024, 32'hbbbb_0002, 0);
    for (int i = 0; i < 5; i++) cyc(0, 2'b01, 0, 64'h0, 32'h0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 2'b00, 0, 64'h0, 32'h0, 1);

    // full then Bubble with a waiting input; input is pushed afterwards
    cyc(0, 2'b00, 1, 64'h8000_0030, 32'hcccc_0001, 0);
    cyc(0, 2'b00, 1, 64'h8000_0034, 32'hcccc_0002, 0);
    cyc(0, 2'b10, 1, 64'h8000_0038, 32'hcccc_0003, 0);
    cyc(0, 2'b00, 1, 64'h8000_0038, 32'hcccc_0003, 0);
    cyc(0, 2'b00, 0, 64'h0, 32'h0, 1);

    // Bubble (reserved encoding) with an accepted push: entry is dropped
    cyc(0, 2'b00, 1, 64'h8000_0040, 32'hdddd_0001, 0);
    cyc(0, 2'b11, 1, 64'h8000_0044, 32'hdddd_0002, 0);
    cyc(0, 2'b00, 0, 64'h0, 32'h0, 1);

    // long stall saturates the 2-bit counter, reset mid-stall clears
    cyc(0, 2'b00, 1, 64'h8000_0050, 32'heeee_0001, 0);
    for (int i = 0; i < 6; i++) cyc(0, 2'b01, 0, 64'h0, 32'h0, 0);
    cyc(1, 2'b01, 0, 64'h0, 32'h0, 0);
    cyc(0, 2'b01, 0, 64'h0, 32'h0, 0);

    // random traffic
    seq      = 0;
    need_new = 1'b1;
    up_v     = 1'b0;
    up_pc    = '0;
    up_d     = '0;
    for (int i = 0; i < 3000; i++) begin
      rr = $urandom_range(0, 99);
      r  = (rr == 0);
      c  = (rr < 80) ? 2'b00 : (rr < 90) ? 2'b01 : (rr < 97) ? 2'b10 : 2'b11;
      if (!hold_pend) begin
        if (need_new) begin
          seq++;
          up_pc    = 64'h9000_0000 + 64'(seq) * 4;
          up_d     = $urandom;
          need_new = 1'b0;
        end
        up_v = ($urandom_range(0, 9) < 7);
      end
      cyc(r, c, up_v, up_pc, up_d, $urandom_range(0, 3) != 0);
      if (up_acc) need_new = 1'b1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
